// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin sharing of one combinational ALU between two
//             requesters. Each requester has a valid/ready request channel
//             and a valid/ready response channel. Operands and opcode are
//             registered into the ALU, the result is captured ALU_LAT cycles
//             later, and a zero flag is derived from it. One operation in
//             flight at a time.
//  Options  : DIVZERO_CHK_EN - divide (0100) with b==0 is answered directly
//             with all-ones and an error flag, never issued to the ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    // shared response data
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_zero,
    output logic             rsp_err,
    // ALU side
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_r
);

    localparam int         c_cnt_w   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(ALU_LAT - 1);
    localparam logic [3:0] c_op_nop  = 4'b0000;
    localparam logic [3:0] c_op_div  = 4'b0100;
    localparam logic [3:0] c_op_last = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_owner;
    logic                 r_last_grant;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_alu_op;
    logic [WIDTH-1:0]     r_alu_a;
    logic [WIDTH-1:0]     r_alu_b;
    logic [WIDTH-1:0]     r_rsp_r;
    logic                 r_rsp_zero;
    logic                 r_rsp_err;

    logic                 w_gnt1;
    logic                 w_rdy0;
    logic                 w_rdy1;
    logic                 w_acc;
    logic [3:0]           w_sel_op;
    logic [WIDTH-1:0]     w_sel_a;
    logic [WIDTH-1:0]     w_sel_b;
    logic                 w_illegal;
    logic                 w_divz;
    logic                 w_cap;
    logic                 w_rsp_hs;

    // Grant selection, accept/capture/handshake qualifiers
    always_comb begin
        // requester 1 wins when it is alone, or when both ask and 0 went last
        w_gnt1    = req1_valid && (!req0_valid || !r_last_grant);
        // ready is suppressed while reset is held so every output reads 0
        w_rdy0    = rst_n && (r_state == S_IDLE) && req0_valid && !w_gnt1;
        w_rdy1    = rst_n && (r_state == S_IDLE) && w_gnt1;
        w_acc     = w_rdy0 || w_rdy1;
        w_sel_op  = w_gnt1 ? req1_op : req0_op;
        w_sel_a   = w_gnt1 ? req1_a  : req0_a;
        w_sel_b   = w_gnt1 ? req1_b  : req0_b;
        w_illegal = (w_sel_op == c_op_nop) || (w_sel_op > c_op_last);
        w_divz    = 1'b0;
`ifdef DIVZERO_CHK_EN
        w_divz    = (w_sel_op == c_op_div) && (w_sel_b == '0);
`endif
        w_cap     = (r_state == S_EXEC) && (r_cnt == '0);
        w_rsp_hs  = (r_state == S_RESP) && (r_owner ? rsp1_ready : rsp0_ready);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = (w_illegal || w_divz) ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_cap) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand load, settle countdown, result capture and ALU opcode release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_alu_op     <= c_op_nop;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_r      <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else if (w_acc) begin
            r_owner      <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_cnt        <= c_cnt_init;
            if (w_illegal) begin
                r_alu_op   <= w_sel_op;
                r_alu_a    <= w_sel_a;
                r_alu_b    <= w_sel_b;
                r_rsp_r    <= '0;
                r_rsp_zero <= 1'b1;
                r_rsp_err  <= 1'b1;
            end else if (w_divz) begin
                // never reaches the ALU: operand registers keep their values
                r_rsp_r    <= '1;
                r_rsp_zero <= 1'b0;
                r_rsp_err  <= 1'b1;
            end else begin
                r_alu_op   <= w_sel_op;
                r_alu_a    <= w_sel_a;
                r_alu_b    <= w_sel_b;
            end
        end else if (r_state == S_EXEC) begin
            if (w_cap) begin
                r_rsp_r    <= alu_r;
                r_rsp_zero <= (alu_r == '0);
                r_rsp_err  <= 1'b0;
            end else begin
                r_cnt      <= r_cnt - 1'b1;
            end
        end else if (w_rsp_hs) begin
            r_alu_op <= c_op_nop;
        end
    end

    assign req0_ready = w_rdy0;
    assign req1_ready = w_rdy1;
    assign rsp0_valid = (r_state == S_RESP) && !r_owner;
    assign rsp1_valid = (r_state == S_RESP) &&  r_owner;
    assign rsp_r      = r_rsp_r;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;
    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter. Instance dut (ALU_LAT=1) is
//             compared every cycle against a transaction-level model; a second
//             instance dut3 (ALU_LAT=3) gets directed latency/reset checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n, rst3_n;
    always #5 clk = ~clk;

    // ---------------- ALU_LAT=1 instance signals ----------------
    logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [3:0]   req0_op, req1_op, alu_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0] rsp_r, alu_a, alu_b, alu_r;
    logic         rsp_zero, rsp_err;

    // ---------------- ALU_LAT=3 instance signals ----------------
    logic         d3_req0_valid, d3_req0_ready, d3_rsp0_valid, d3_rsp0_ready;
    logic         d3_req1_valid, d3_req1_ready, d3_rsp1_valid, d3_rsp1_ready;
    logic [3:0]   d3_req0_op, d3_req1_op, d3_alu_op;
    logic [W-1:0] d3_req0_a, d3_req0_b, d3_req1_a, d3_req1_b;
    logic [W-1:0] d3_rsp_r, d3_alu_a, d3_alu_b, d3_alu_r;
    logic         d3_rsp_zero, d3_rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Stand-in ALU: 1 add, 2 sub, 3 mul, 4 divu, 5 and, 6 or, 7 xor,
    // 8 sll, 9 srl, 10 pass-a, 11 pass-b
    function automatic logic [W-1:0] alu_fn(input logic [3:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a * b;
            4'd4:    return (b == '0) ? '1 : a / b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return a << b[4:0];
            4'd9:    return a >> b[4:0];
            4'd10:   return a;
            4'd11:   return b;
            default: return '0;
        endcase
    endfunction

    always_comb alu_r    = alu_fn(alu_op, alu_a, alu_b);
    always_comb d3_alu_r = alu_fn(d3_alu_op, d3_alu_a, d3_alu_b);

    alu_arbiter #(.WIDTH(W), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_r(rsp_r), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r)
    );

    alu_arbiter #(.WIDTH(W), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready), .req0_op(d3_req0_op),
        .req0_a(d3_req0_a), .req0_b(d3_req0_b),
        .rsp0_valid(d3_rsp0_valid), .rsp0_ready(d3_rsp0_ready),
        .req1_valid(d3_req1_valid), .req1_ready(d3_req1_ready), .req1_op(d3_req1_op),
        .req1_a(d3_req1_a), .req1_b(d3_req1_b),
        .rsp1_valid(d3_rsp1_valid), .rsp1_ready(d3_rsp1_ready),
        .rsp_r(d3_rsp_r), .rsp_zero(d3_rsp_zero), .rsp_err(d3_rsp_err),
        .alu_op(d3_alu_op), .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_r(d3_alu_r)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model of dut ----------------
    // m_free: no operation owned; m_wait: edges left until the result lands;
    // m_resp: a response is being offered to m_owner.
    bit           m_free, m_resp, m_owner, m_last;
    int           m_wait;
    logic [3:0]   m_op;
    logic [W-1:0] m_a, m_b, m_r;
    bit           m_zero, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_free = 1; m_resp = 0; m_owner = 0; m_last = 1; m_wait = 0;
            m_op = '0; m_a = '0; m_b = '0; m_r = '0; m_zero = 0; m_err = 0;
        end else if (m_free) begin
            bit           who, take;
            logic [3:0]   op;
            logic [W-1:0] a, b;
            who  = req1_valid && (!req0_valid || !m_last);
            take = req0_valid || req1_valid;
            op   = who ? req1_op : req0_op;
            a    = who ? req1_a  : req0_a;
            b    = who ? req1_b  : req0_b;
            if (take) begin
                m_free = 0; m_owner = who; m_last = who;
                if (op == 4'd0 || op >= 4'd12) begin
                    m_op = op; m_a = a; m_b = b;
                    m_r = '0; m_zero = 1; m_err = 1; m_resp = 1;
                end
`ifdef DIVZERO_CHK_EN
                else if (op == 4'd4 && b == '0) begin
                    m_r = '1; m_zero = 0; m_err = 1; m_resp = 1;
                end
`endif
                else begin
                    m_op = op; m_a = a; m_b = b; m_wait = 1;
                end
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_r = alu_fn(m_op, m_a, m_b);
                m_zero = (m_r == '0); m_err = 0; m_resp = 1;
            end
        end else if (m_resp && (m_owner ? rsp1_ready : rsp0_ready)) begin
            m_resp = 0; m_free = 1; m_op = '0;
        end
    end

    // Cycle-by-cycle comparison of dut against the model
    always @(negedge clk) begin
        bit g1;
        g1 = req1_valid && (!req0_valid || !m_last);
        check("cmp_req0_ready", req0_ready, rst_n && m_free && req0_valid && !g1);
        check("cmp_req1_ready", req1_ready, rst_n && m_free && g1);
        check("cmp_rsp0_valid", rsp0_valid, m_resp && !m_owner);
        check("cmp_rsp1_valid", rsp1_valid, m_resp &&  m_owner);
        check("cmp_rsp_r",      rsp_r,      m_r);
        check("cmp_rsp_zero",   rsp_zero,   m_zero);
        check("cmp_rsp_err",    rsp_err,    m_err);
        check("cmp_alu_op",     alu_op,     m_op);
        check("cmp_alu_a",      alu_a,      m_a);
        check("cmp_alu_b",      alu_b,      m_b);
    end

    // Bounded wait on dut: 0 req0_ready, 1 req1_ready, 2 rsp0_valid, 3 rsp1_valid
    task automatic wait_sig(input int which, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            case (which)
                0:       seen = req0_ready;
                1:       seen = req1_ready;
                2:       seen = rsp0_valid;
                default: seen = rsp1_valid;
            endcase
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: timeout, got 0 expected 1", name);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer an op on requester 0, hold until accepted, then drop valid
    task automatic issue0(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name);
        req0_op = op; req0_a = a; req0_b = b; req0_valid = 1;
        wait_sig(0, name);
        step();
        req0_valid = 0;
    endtask

    initial begin
        logic [W-1:0] held;
        rst_n = 0; rst3_n = 0;
        {req0_valid, rsp0_ready, req1_valid, rsp1_ready} = '0;
        {req0_op, req1_op} = '0; {req0_a, req0_b, req1_a, req1_b} = '0;
        {d3_req0_valid, d3_rsp0_ready, d3_req1_valid, d3_rsp1_ready} = '0;
        {d3_req0_op, d3_req1_op} = '0;
        {d3_req0_a, d3_req0_b, d3_req1_a, d3_req1_b} = '0;

        // reset: outputs 0 even with a request pending
        repeat (2) step();
        req0_valid = 1;
        @(negedge clk);
        check("reset_req0_ready", req0_ready, 0);
        check("reset_rsp_r", rsp_r, 0);
        check("reset_alu_op", alu_op, 0);
        check("reset_d3_ready", d3_req0_ready, 0);
        req0_valid = 0;
        step();
        rst_n = 1; rst3_n = 1;

        // T1: add 5+7
        req0_op = 4'd1; req0_a = 5; req0_b = 7; req0_valid = 1; rsp0_ready = 1;
        @(negedge clk);
        check("t1_req0_ready", req0_ready, 1);
        step();
        req0_valid = 0;
        @(negedge clk);
        check("t1_exec_no_valid", rsp0_valid, 0);
        check("t1_alu_op_loaded", alu_op, 4'd1);
        @(negedge clk);
        check("t1_rsp0_valid", rsp0_valid, 1);
        check("t1_rsp_r", rsp_r, 12);
        check("t1_rsp_zero", rsp_zero, 0);
        check("t1_rsp_err", rsp_err, 0);
        step();
        @(negedge clk);
        check("t1_alu_op_clear", alu_op, 0);
        check("t1_alu_a_hold", alu_a, 5);

        // T2: both valid from reset, then alternation
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        req0_op = 4'd2; req0_a = 9;     req0_b = 9;
        req1_op = 4'd6; req1_a = 'hF0;  req1_b = 'h0F;
        req0_valid = 1; req1_valid = 1; rsp1_ready = 1;
        @(negedge clk);
        check("t2_first_req0", req0_ready, 1);
        check("t2_first_not_req1", req1_ready, 0);
        step();
        req0_valid = 0;
        wait_sig(2, "t2_rsp0");
        check("t2_sub_r", rsp_r, 0);
        check("t2_sub_zero", rsp_zero, 1);
        wait_sig(1, "t2_grant1");
        step();
        req1_valid = 0;
        wait_sig(3, "t2_rsp1");
        check("t2_or_r", rsp_r, 32'hFF);
        check("t2_or_zero", rsp_zero, 0);
        step();
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        check("t2_alt_req0", req0_ready, 1);
        check("t2_alt_not_req1", req1_ready, 0);
        step();
        req0_valid = 0; req1_valid = 0;
        wait_sig(2, "t2_rsp0b");
        step();

        // T3: response back-pressure, waiting requester held off
        rsp1_ready = 0;
        req1_op = 4'd11; req1_a = 0; req1_b = 32'h1234; req1_valid = 1;
        wait_sig(1, "t3_grant1");
        step();
        req1_valid = 0;
        req1_b = 32'hDEAD;                       // late change must not matter
        req0_op = 4'd1; req0_a = 1; req0_b = 1; req0_valid = 1;
        wait_sig(3, "t3_rsp1");
        held = rsp_r;
        check("t3_rsp_r", held, 32'h1234);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", rsp1_valid, 1);
            check("t3_hold_r", rsp_r, held);
            check("t3_no_grant", req0_ready, 0);
        end
        step();
        rsp1_ready = 1;
        @(negedge clk);
        check("t3_hs_cycle_no_grant", req0_ready, 0);
        step();
        @(negedge clk);
        check("t3_grant_after_hs", req0_ready, 1);
        step();
        req0_valid = 0;
        wait_sig(2, "t3_rsp0");
        check("t3_add_r", rsp_r, 2);
        step();

        // T4: illegal opcode skips execution
        issue0(4'b1110, 3, 4, "t4_grant");
        @(negedge clk);
        check("t4_rsp0_valid", rsp0_valid, 1);
        check("t4_rsp_r", rsp_r, 0);
        check("t4_rsp_err", rsp_err, 1);
        step();

        // T5: divide by zero, then a normal divide
        issue0(4'd4, 10, 0, "t5_grant");
        @(negedge clk);
`ifdef DIVZERO_CHK_EN
        check("t5_dz_valid", rsp0_valid, 1);
        check("t5_dz_r", rsp_r, 32'hFFFF_FFFF);
        check("t5_dz_err", rsp_err, 1);
        check("t5_dz_alu_op", alu_op, 0);
`else
        check("t5_div_issued", alu_op, 4'd4);
        @(negedge clk);
        check("t5_div_valid", rsp0_valid, 1);
        check("t5_div_err", rsp_err, 0);
`endif
        step();
        issue0(4'd4, 100, 7, "t5b_grant");
        wait_sig(2, "t5b_rsp0");
        check("t5b_div_r", rsp_r, 14);
        step();

        // T6: ALU_LAT=3, truncated multiply, then reset mid-execution
        d3_req0_op = 4'd3; d3_req0_a = 32'h10000; d3_req0_b = 32'h10000;
        d3_req0_valid = 1; d3_rsp0_ready = 1;
        @(negedge clk);
        check("t6_d3_ready", d3_req0_ready, 1);
        step();
        d3_req0_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t6_d3_latency", d3_rsp0_valid, (i == 4) ? 1 : 0);
        end
        check("t6_d3_mul_r", d3_rsp_r, 0);
        check("t6_d3_mul_zero", d3_rsp_zero, 1);
        step();
        d3_req0_op = 4'd1; d3_req0_a = 1; d3_req0_b = 2; d3_req0_valid = 1;
        @(negedge clk);
        check("t6_d3_ready2", d3_req0_ready, 1);
        step();
        d3_req0_valid = 0;
        @(negedge clk);
        check("t6_d3_op_loaded", d3_alu_op, 4'd1);
        #1 rst3_n = 0;
        #1;
        check("t6_rst_alu_op", d3_alu_op, 0);
        check("t6_rst_alu_a", d3_alu_a, 0);
        check("t6_rst_alu_b", d3_alu_b, 0);
        check("t6_rst_zero", d3_rsp_zero, 0);
        step();
        rst3_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6_no_rsp_after_rst", d3_rsp0_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational 32-bit ALU between two requesters (e.g. the integer pipe and the address/branch unit).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Requesters are granted round-robin. The arbiter registers operands and opcode into the ALU, waits a fixed settle time, then captures the result and computes zero.
- One operation is in flight at a time.

Parameters:
WIDTH, 32, operand/result width; must match the ALU.
ALU_LAT, 1, cycles from operand register load to result capture (>=1; raise for mult/div timing closure).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_op  in  4  ALU opcode (0001 add … 1011 pass-b).
req0_a, req0_b  in  WIDTH  operands.
rsp0_valid  out  1  result for requester 0 available.
rsp0_ready  in  1  requester 0 consumes result.
req1_*, rsp1_*  same set for requester 1.
rsp_r  out  WIDTH  result data, shared by both response channels.
rsp_zero  out  1  rsp_r == 0.
rsp_err  out  1  opcode illegal (or div-by-zero, see option).
alu_op  out  4  to ALU ALUop.
alu_a, alu_b  out  WIDTH  to ALU a/b.
alu_r  in  WIDTH  from ALU r.

Behaviour:
- Reset (async, rst_n low): state=IDLE; every output is 0: req*_ready, rsp*_valid, rsp_r, rsp_zero, rsp_err, alu_op, alu_a, alu_b. last_grant=1, so req0 wins first. Any in-flight operation is discarded with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - One valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - req*_ready is combinational: high only for the granted requester, only in IDLE.
- IDLE, accept: handshake at clock edge E0 (valid&ready).
  - Load alu_op/alu_a/alu_b from the granted requester.
  - Record owner; last_grant<=owner; cnt<=ALU_LAT-1.
  - Legal op: go to EXEC. Illegal op (0000, 1100-1111): skip EXEC, go to RESP with rsp_r=0, rsp_err=1.
- EXEC:
  - If cnt!=0, decrement cnt.
  - If cnt==0: capture rsp_r<=alu_r, rsp_zero<=(alu_r==0), rsp_err<=0, go to RESP.
  - Capture edge is E0+ALU_LAT; rsp*_valid is high in the cycle after it.
- RESP:
  - rspN_valid high for the owner only, held stable with data until rspN_ready.
  - On handshake: go to IDLE, alu_op<=0000. alu_a/alu_b hold their values.
  - rsp_r/zero/err hold until the next capture.
  - No new grant in the handshake cycle: minimum issue interval is ALU_LAT+2 cycles.
- Operand stability:
  - alu_a/alu_b/alu_op change only at accept or at the return to IDLE.
  - Requester operand changes after acceptance have no effect.
- Requester behaviour rules:
  - A requester dropping valid before ready: nothing is accepted; legal.
  - rspN_ready asserted while not owner: ignored.
- Arithmetic: the arbiter does no arithmetic; results are WIDTH bits as returned by the ALU (mult truncated, div unsigned).

Optional Feature:
Macro DIVZERO_CHK_EN.
- Defined: op 0100 with b==0 is not issued to the ALU. alu_op stays 0000; go directly from IDLE to RESP with rsp_r=32'hFFFFFFFF, rsp_zero=0, rsp_err=1.
- Undefined: op 0100 is issued normally regardless of b; rsp_err=0 and rsp_r is whatever the ALU returns.

Test Plan:
- Reset, then req0 add a=5 b=7 (ALU_LAT=1), rsp0_ready=1 → req0_ready in the accept cycle; rsp0_valid one cycle after the accept edge; rsp_r=12, rsp_zero=0, rsp_err=0; alu_op back to 0000 after the response.
- Both valid from reset: req0 sub 9-9, req1 or 0xF0|0x0F → req0 served first with rsp_r=0, rsp_zero=1; then req1 with rsp_r=0xFF; a third simultaneous pair grants req0 again (alternation).
- rsp1_ready held low 5 cycles after rsp1_valid → rsp1_valid and rsp_r stay stable; req0_valid high is not granted until one cycle after the rsp1 handshake.
- req0 op=4'b1110 → no EXEC; rsp0_valid one cycle after accept with rsp_r=0, rsp_err=1.
- ALU_LAT=3, mult 0x10000×0x10000 → rsp_r=0 (truncated), rsp_zero=1, valid exactly 3 cycles after accept; rst_n pulsed low mid-EXEC on a second op → outputs 0 immediately, no response.
- DIVZERO_CHK_EN defined, div a=10 b=0 → rsp_r=FFFFFFFF, rsp_err=1, alu_op never 0100. Undefined: alu_op=0100 and rsp_err=0.
